// File: rtl/sequence_checker.sv
// Simon Says sequence store and player-input checker.
// Holds up to MAX_ROUNDS random colours, replays them on timer steps and
// grades switch presses against the stored sequence, one press at a time.
module sequence_checker #(
    parameter int          MAX_ROUNDS = 63,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       add_req,
    input  logic       play_req,
    input  logic       step,
    input  logic       check_req,
    input  logic [3:0] player_input,
    output logic [3:0] colour,
    output logic       add_done,
    output logic       full,
    output logic       play_done,
    output logic       result_valid,
    output logic       result,
    output logic       round_done,
    output logic [5:0] round_len,
    output logic       busy
);

    // An all-zero Galois LFSR would lock up, so a zero seed is remapped.
    localparam logic [15:0] SEED    = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [5:0]  MAX_LEN = 6'(MAX_ROUNDS);

    typedef enum logic [1:0] {IDLE, PLAY, WAIT_IN, WAIT_REL} state_t;

    function automatic logic [3:0] onehot(input logic [1:0] c);
        onehot = 4'b0001 << c;
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  mem_q [64];
    logic [15:0] lfsr_q, lfsr_d;
    logic [5:0]  len_q, len_d;
    logic [5:0]  idx_q, idx_d;
    logic [3:0]  colour_q, colour_d;
    logic        add_done_q, add_done_d;
    logic        full_q, full_d;
    logic        play_done_q, play_done_d;
    logic        rv_q, rv_d;
    logic        result_q, result_d;
    logic        round_done_q, round_done_d;
    logic        busy_q, busy_d;
    logic        mem_we;

    logic [3:0]  cur_colour, nxt_colour;
    logic        last;

    assign cur_colour = onehot(mem_q[idx_q]);
    // idx+1 may wrap at 63, but it is only used while idx < len-1.
    assign nxt_colour = onehot(mem_q[idx_q + 6'd1]);
    assign last       = (idx_q == len_q - 6'd1);

    // Free-running LFSR; advancing every cycle lets player timing pick colours.
    always_comb begin
        lfsr_d = lfsr_q >> 1;
        if (lfsr_q[0]) lfsr_d = (lfsr_q >> 1) ^ 16'hB400;
    end

    // Next-state and registered-output logic for the command FSM.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        idx_d        = idx_q;
        colour_d     = colour_q;
        result_d     = result_q;
        add_done_d   = 1'b0;
        play_done_d  = 1'b0;
        rv_d         = 1'b0;
        round_done_d = 1'b0;
        mem_we       = 1'b0;
        unique case (state_q)
            IDLE: begin
                colour_d = 4'b0000;
                if (add_req) begin
                    add_done_d = 1'b1;
                    if (len_q < MAX_LEN) begin
                        mem_we = 1'b1;
                        len_d  = len_q + 6'd1;
                    end
                end else if (play_req) begin
                    if (len_q == 6'd0) begin
                        play_done_d = 1'b1;
                    end else begin
                        idx_d    = 6'd0;
                        colour_d = onehot(mem_q[0]);
                        state_d  = PLAY;
                    end
                end else if (check_req) begin
                    if (len_q == 6'd0) begin
                        round_done_d = 1'b1;
                    end else begin
                        idx_d   = 6'd0;
                        state_d = WAIT_IN;
                    end
                end
            end
            PLAY: begin
                if (step) begin
                    if (last) begin
                        colour_d    = 4'b0000;
                        play_done_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        idx_d    = idx_q + 6'd1;
                        colour_d = nxt_colour;
                    end
                end
            end
            WAIT_IN: begin
                // Exact compare, so multi-hot presses grade as wrong.
                if (player_input != 4'b0000) begin
                    result_d = (player_input == cur_colour);
                    rv_d     = 1'b1;
                    state_d  = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (player_input == 4'b0000) begin
                    if (!result_q) begin
                        state_d = IDLE;
                    end else if (last) begin
                        round_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        state_d = WAIT_IN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        full_d = (len_d == MAX_LEN);
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any operation without pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            lfsr_q       <= SEED;
            len_q        <= 6'd0;
            idx_q        <= 6'd0;
            colour_q     <= 4'b0000;
            add_done_q   <= 1'b0;
            full_q       <= 1'b0;
            play_done_q  <= 1'b0;
            rv_q         <= 1'b0;
            result_q     <= 1'b0;
            round_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            colour_q     <= colour_d;
            add_done_q   <= add_done_d;
            full_q       <= full_d;
            play_done_q  <= play_done_d;
            rv_q         <= rv_d;
            result_q     <= result_d;
            round_done_q <= round_done_d;
            busy_q       <= busy_d;
        end
    end

    // Sequence storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[len_q] <= lfsr_q[1:0];
    end

    assign colour       = colour_q;
    assign add_done     = add_done_q;
    assign full         = full_q;
    assign play_done    = play_done_q;
    assign result_valid = rv_q;
    assign result       = result_q;
    assign round_done   = round_done_q;
    assign round_len    = len_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_sequence_checker.sv
// Directed bench for sequence_checker: a vector table for command handling,
// then hand-written sequences for playback, grading, full and reset abort.
module tb_sequence_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       add_req = 1'b0, play_req = 1'b0, step = 1'b0, check_req = 1'b0;
    logic [3:0] player_input = 4'b0000;
    logic [3:0] colour;
    logic       add_done, full, play_done, result_valid, result, round_done, busy;
    logic [5:0] round_len;

    int checks = 0;
    int failures = 0;

    sequence_checker dut (
        .clk(clk), .reset(reset), .add_req(add_req), .play_req(play_req),
        .step(step), .check_req(check_req), .player_input(player_input),
        .colour(colour), .add_done(add_done), .full(full), .play_done(play_done),
        .result_valid(result_valid), .result(result), .round_done(round_done),
        .round_len(round_len), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       a, p, s, c;
        logic [3:0] pin;
        logic       e_ad, e_pd, e_rv, e_res, e_rd, e_full, e_busy;
        logic [5:0] e_len;
    } vec_t;

    vec_t vt [13];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic add_one();
        add_req = 1'b1;
        tick();
        add_req = 1'b0;
    endtask

    logic [3:0] S [3];
    logic [3:0] wrong;
    logic       seen;

    initial begin
        // a p s c pin | ad pd rv res rd full busy len
        vt[0]  = '{1'b0,1'b0,1'b0,1'b0,4'h0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,6'd0};
        vt[1]  = '{1'b0,1'b1,1'b0,1'b0,4'h0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,6'd0};
        vt[2]  = '{1'b0,1'b0,1'b0,1'b0,4'h0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,6'd0};
        vt[3]  = '{1'b0,1'b0,1'b0,1'b1,4'h0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,6'd0};
        vt[4]  = '{1'b0,1'b0,1'b1,1'b0,4'h0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,6'd0};
        vt[5]  = '{1'b0,1'b0,1'b0,1'b0,4'h1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,6'd0};
        vt[6]  = '{1'b1,1'b0,1'b0,1'b0,4'h0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,6'd1};
        vt[7]  = '{1'b0,1'b0,1'b0,1'b0,4'h0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,6'd1};
        vt[8]  = '{1'b1,1'b1,1'b0,1'b1,4'h0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,6'd2};
        vt[9]  = '{1'b0,1'b0,1'b0,1'b0,4'h0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,6'd2};
        vt[10] = '{1'b0,1'b0,1'b0,1'b0,4'h0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,6'd2};
        vt[11] = '{1'b1,1'b0,1'b0,1'b0,4'h0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,6'd3};
        vt[12] = '{1'b0,1'b0,1'b0,1'b0,4'h0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,6'd3};

        // Reset state
        tick();
        chk("rst_colour", int'(colour), 0);
        chk("rst_len", int'(round_len), 0);
        chk("rst_flags", int'({add_done, full, play_done, result_valid, result, round_done, busy}), 0);
        tick();
        reset = 1'b0;

        // Command table: empty-sequence responses, ignored inputs, adds, priority
        for (int i = 0; i < 13; i++) begin
            add_req = vt[i].a; play_req = vt[i].p; step = vt[i].s;
            check_req = vt[i].c; player_input = vt[i].pin;
            tick();
            chk($sformatf("vec%0d_add_done", i), int'(add_done), int'(vt[i].e_ad));
            chk($sformatf("vec%0d_play_done", i), int'(play_done), int'(vt[i].e_pd));
            chk($sformatf("vec%0d_rvalid", i), int'(result_valid), int'(vt[i].e_rv));
            chk($sformatf("vec%0d_result", i), int'(result), int'(vt[i].e_res));
            chk($sformatf("vec%0d_round_done", i), int'(round_done), int'(vt[i].e_rd));
            chk($sformatf("vec%0d_full", i), int'(full), int'(vt[i].e_full));
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(vt[i].e_busy));
            chk($sformatf("vec%0d_len", i), int'(round_len), int'(vt[i].e_len));
            chk($sformatf("vec%0d_colour", i), int'(colour), 0);
        end
        add_req = 0; play_req = 0; step = 0; check_req = 0; player_input = 0;

        // Playback of three entries
        play_req = 1'b1;
        tick();
        play_req = 1'b0;
        chk("play0_busy", int'(busy), 1);
        chk("play0_onehot", int'($onehot(colour)), 1);
        chk("play0_done", int'(play_done), 0);
        S[0] = colour;
        tick();
        chk("play0_hold", int'($onehot(colour)), 1);
        for (int k = 1; k < 3; k++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            chk($sformatf("play%0d_onehot", k), int'($onehot(colour)), 1);
            chk($sformatf("play%0d_done", k), int'(play_done), 0);
            S[k] = colour;
            tick();
            chk($sformatf("play%0d_hold", k), int'($onehot(colour)), 1);
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("play_end_colour", int'(colour), 0);
        chk("play_end_done", int'(play_done), 1);
        chk("play_end_busy", int'(busy), 0);
        tick();
        chk("play_done_pulse", int'(play_done), 0);

        // Correct round
        check_req = 1'b1;
        tick();
        check_req = 1'b0;
        chk("chk_busy", int'(busy), 1);
        chk("chk_rv_idle", int'(result_valid), 0);
        for (int k = 0; k < 3; k++) begin
            player_input = S[k];
            tick();
            chk($sformatf("press%0d_rv", k), int'(result_valid), 1);
            chk($sformatf("press%0d_res", k), int'(result), 1);
            tick();
            chk($sformatf("press%0d_rv_pulse", k), int'(result_valid), 0);
            player_input = 4'b0000;
            tick();
            chk($sformatf("rel%0d_round_done", k), int'(round_done), (k == 2) ? 1 : 0);
            chk($sformatf("rel%0d_busy", k), int'(busy), (k == 2) ? 0 : 1);
        end
        tick();
        chk("round_done_pulse", int'(round_done), 0);

        // Wrong presses: wrong one-hot colour, then multi-hot
        for (int t = 0; t < 2; t++) begin
            wrong = (S[0] == 4'b0001) ? 4'b0010 : 4'b0001;
            if (t == 1) wrong = 4'b0110;
            check_req = 1'b1;
            tick();
            check_req = 1'b0;
            player_input = wrong;
            tick();
            chk($sformatf("wrong%0d_rv", t), int'(result_valid), 1);
            chk($sformatf("wrong%0d_res", t), int'(result), 0);
            player_input = 4'b0000;
            tick();
            chk($sformatf("wrong%0d_busy", t), int'(busy), 0);
            chk($sformatf("wrong%0d_round_done", t), int'(round_done), 0);
            chk($sformatf("wrong%0d_res_hold", t), int'(result), 0);
            tick();
            chk($sformatf("wrong%0d_round_done2", t), int'(round_done), 0);
        end

        // Fill to MAX_ROUNDS, then one more add
        do_reset();
        for (int i = 0; i < 63; i++) begin
            add_one();
            chk($sformatf("fill%0d_len", i), int'(round_len), i + 1);
            if (i >= 61) chk($sformatf("fill%0d_full", i), int'(full), (i == 62) ? 1 : 0);
        end
        chk("fill_add_done", int'(add_done), 1);
        tick();
        add_one();
        chk("over_add_done", int'(add_done), 1);
        chk("over_len", int'(round_len), 63);
        chk("over_full", int'(full), 1);

        // Reset in the middle of playback; commands during PLAY ignored
        do_reset();
        for (int i = 0; i < 3; i++) add_one();
        play_req = 1'b1;
        tick();
        play_req = 1'b0;
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("mid_busy", int'(busy), 1);
        play_req = 1'b1;
        check_req = 1'b1;
        tick();
        play_req = 1'b0;
        check_req = 1'b0;
        chk("mid_cmd_busy", int'(busy), 1);
        chk("mid_cmd_onehot", int'($onehot(colour)), 1);
        chk("mid_cmd_play_done", int'(play_done), 0);
        chk("mid_cmd_round_done", int'(round_done), 0);
        #2 reset = 1'b1;
        #1;
        chk("abort_colour", int'(colour), 0);
        chk("abort_len", int'(round_len), 0);
        chk("abort_busy", int'(busy), 0);
        tick();
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (play_done) seen = 1'b1;
        end
        chk("abort_no_play_done", int'(seen), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
